// File: rtl/fir_stream_engine.sv
// -----------------------------------------------------------------------------
// fir_stream_engine
//
// FIR filter engine that sits directly downstream of two simple dual-port
// BRAMs: a tap RAM, which this block only reads, and a data RAM, which it uses
// as a circular sample buffer. Input samples arrive on an AXI-Stream slave.
// Each accepted sample is written into the circular buffer. The engine then
// walks all taps and emits one filtered result on an AXI-Stream master.
// A run is started by ap_start and processes exactly data_length samples.
//
// Ports
//   axis_clk, axis_rst_n        clock, asynchronous active-low reset
//   ap_start, data_length       run start pulse and sample count (latched)
//   ap_idle, ap_done            engine idle; one-cycle end-of-run pulse
//   ss_tvalid/tdata/tlast/tready  sample input stream (tlast is not used)
//   sm_tvalid/tdata/tlast/tready  result output stream
//   tap_re, tap_raddr, tap_rdo  tap RAM read port (1-cycle read latency)
//   dat_we, dat_waddr, dat_wdi  data RAM write port
//   dat_re, dat_raddr, dat_rdo  data RAM read port (1-cycle read latency)
// -----------------------------------------------------------------------------
module fir_stream_engine #(
  parameter int NTAP       = 11,
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  ap_start,
  input  logic [31:0]           data_length,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ss_tvalid,
  input  logic [BIT_WIDTH-1:0]  ss_tdata,
  input  logic                  ss_tlast,
  output logic                  ss_tready,
  output logic                  sm_tvalid,
  output logic [BIT_WIDTH-1:0]  sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready,
  output logic [3:0]            tap_re,
  output logic [ADDR_WIDTH-1:0] tap_raddr,
  input  logic [BIT_WIDTH-1:0]  tap_rdo,
  output logic [3:0]            dat_we,
  output logic [3:0]            dat_re,
  output logic [ADDR_WIDTH-1:0] dat_waddr,
  output logic [ADDR_WIDTH-1:0] dat_raddr,
  output logic [BIT_WIDTH-1:0]  dat_wdi,
  input  logic [BIT_WIDTH-1:0]  dat_rdo
);

  // The index counter must be able to hold NTAP itself. That value marks the
  // MAC drain cycle, in which no read is issued and only the last product is
  // accumulated.
  localparam int IW = $clog2(NTAP + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAP - 1);
  localparam logic [IW-1:0] DRAIN    = IW'(NTAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t               state;
  logic [31:0]          len;
  logic [31:0]          count;
  logic [IW-1:0]        head;   // buffer slot that holds the newest sample
  logic [IW-1:0]        idx;    // clear address in CLEAR, tap index in MAC
  logic [IW-1:0]        rptr;   // (head - idx) mod NTAP, walked downwards
  logic [BIT_WIDTH-1:0] acc;
  logic [BIT_WIDTH-1:0] prod;
  logic                 in_hs;
  logic                 last_out;

  // ss_tlast is informational only; the run length comes from data_length.
  logic unused_tlast;
  assign unused_tlast = ss_tlast;

  // Only the low BIT_WIDTH bits of the product are kept. Those bits are the
  // same for signed and unsigned operands, so no sign extension is needed.
  assign prod     = tap_rdo * dat_rdo;
  assign in_hs    = ss_tvalid && ss_tready;
  assign last_out = (count == len - 32'd1);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    // NOTE: state registers use non-blocking assignments so that every
    // register samples pre-edge values, whatever order the statements are in.
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      count     <= '0;
      head      <= '0;
      idx       <= '0;
      rptr      <= '0;
      acc       <= '0;
      ap_idle   <= 1'b1;
      ap_done   <= 1'b0;
      ss_tready <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      sm_tlast  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            len     <= data_length;
            idx     <= '0;
            ap_idle <= 1'b0;
            state   <= S_CLEAR;
          end
        end

        // Zero the whole circular buffer so a run never sees old history.
        S_CLEAR: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            head  <= '0;
            count <= '0;
            if (len == 32'd0) begin
              ap_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              ss_tready <= 1'b1;
              state     <= S_WAIT_IN;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // The sample is written into slot head in this same cycle. The first
        // MAC read of that slot comes one cycle later, so it returns the new
        // sample.
        S_WAIT_IN: begin
          if (in_hs) begin
            ss_tready <= 1'b0;
            idx       <= '0;
            rptr      <= head;
            state     <= S_MAC;
          end
        end

        // Cycle idx issues read pair idx and accumulates the data of pair
        // idx-1. The extra drain cycle (idx == NTAP) folds in the last product.
        S_MAC: begin
          if (idx != DRAIN) begin
            rptr <= (rptr == '0) ? LAST_IDX : rptr - 1'b1;
          end
          if (idx == '0) begin
            acc <= '0;
          end else begin
            acc <= acc + prod;
          end
          if (idx == DRAIN) begin
            sm_tdata  <= acc + prod;
            sm_tvalid <= 1'b1;
            sm_tlast  <= last_out;
            state     <= S_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            count     <= count + 32'd1;
            head      <= (head == LAST_IDX) ? '0 : head + 1'b1;
            if (last_out) begin
              ap_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              ss_tready <= 1'b1;
              state     <= S_WAIT_IN;
            end
          end
        end

        S_DONE: begin
          ap_done <= 1'b0;
          ap_idle <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes follow the current state, so a write can land in the same
  // cycle as the input handshake.
  always_comb begin
    // NOTE: every output gets a default first, so a path that does not assign
    // it cannot infer a latch.
    tap_re    = '0;
    dat_re    = '0;
    dat_we    = '0;
    tap_raddr = '0;
    dat_raddr = '0;
    dat_waddr = '0;
    dat_wdi   = '0;
    case (state)
      S_CLEAR: begin
        dat_we    = '1;
        dat_waddr = ADDR_WIDTH'(idx);
      end
      S_WAIT_IN: begin
        if (in_hs) begin
          dat_we    = '1;
          dat_waddr = ADDR_WIDTH'(head);
          dat_wdi   = ss_tdata;
        end
      end
      S_MAC: begin
        if (idx != DRAIN) begin
          tap_re    = '1;
          dat_re    = '1;
          tap_raddr = ADDR_WIDTH'(idx);
          dat_raddr = ADDR_WIDTH'(rptr);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_fir_stream_engine
//
// Bench for fir_stream_engine. It models the tap RAM and the data RAM with
// one-cycle reads. Expected results go into a queue as each run is set up,
// and they are popped when the DUT completes an output handshake.
// Deterministic runs come from a table of hand-derived vectors. A random run
// is checked against a 32-bit wrapping FIR model. Hand-written sequences cover
// latency, ap_start during MAC, a zero-length run and reset in the middle of
// a run.
// -----------------------------------------------------------------------------
module tb_fir_stream_engine;

  localparam int NTAP = 11;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [31:0] data_length = '0;
  logic        ap_idle, ap_done;
  logic        ss_tvalid = 1'b0;
  logic [31:0] ss_tdata = '0;
  logic        ss_tlast = 1'b0;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready = 1'b0;
  logic [3:0]  tap_re, dat_we, dat_re;
  logic [11:0] tap_raddr, dat_waddr, dat_raddr;
  logic [31:0] tap_rdo, dat_rdo, dat_wdi;

  always #5 axis_clk = ~axis_clk;

  fir_stream_engine #(.NTAP(NTAP), .ADDR_WIDTH(12), .BIT_WIDTH(32)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .ap_start   (ap_start),
    .data_length(data_length),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready),
    .tap_re     (tap_re),
    .tap_raddr  (tap_raddr),
    .tap_rdo    (tap_rdo),
    .dat_we     (dat_we),
    .dat_re     (dat_re),
    .dat_waddr  (dat_waddr),
    .dat_raddr  (dat_raddr),
    .dat_wdi    (dat_wdi),
    .dat_rdo    (dat_rdo)
  );

  // BRAM models. While reset is held, the data RAM is filled with junk, so a
  // missing CLEAR would leak into the results.
  logic [31:0] tap_mem [16];
  logic [31:0] dat_mem [16];
  always @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < 16; i++) dat_mem[i] <= 32'h5a5a_0000 + i;
    end else if (dat_we[0]) begin
      dat_mem[dat_waddr[3:0]] <= dat_wdi;
    end
    if (tap_re[0]) tap_rdo <= tap_mem[tap_raddr[3:0]];
    if (dat_re[0]) dat_rdo <= dat_mem[dat_raddr[3:0]];
  end

  // Free-running event counters; tests compare deltas around each run.
  int cyc = 0, done_cnt = 0, valid_cnt = 0, tready_cnt = 0;
  always @(posedge axis_clk) begin
    cyc++;
    if (ap_done)   done_cnt++;
    if (sm_tvalid) valid_cnt++;
    if (ss_tready) tready_cnt++;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]            len;
    logic [31:0]            gap_pct;
    logic [31:0]            stall_pct;
    logic [10:0][31:0]      taps;
    logic [19:0][31:0]      din;
    logic [19:0][31:0]      dout;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] in_q [$];
  logic [31:0] exp_q [$];

  task automatic wait_idle();
    int n = 0;
    while (!ap_idle && n < 500) begin
      @(negedge axis_clk);
      n++;
    end
    check("idle_reached", {31'd0, ap_idle}, 32'd1);
  endtask

  task automatic start_run(input int len);
    @(negedge axis_clk);
    data_length = len;
    ap_start    = 1'b1;
    @(negedge axis_clk);
    ap_start = 1'b0;
    check("idle_low_after_start", {31'd0, ap_idle}, 32'd0);
  endtask

  // Drives in_q with random input gaps and consumes results with random
  // backpressure. Each result is compared against exp_q.
  task automatic run_stream(input int len, input int gap_pct, input int stall_pct);
    fork
      begin
        for (int k = 0; k < len; k++) begin
          int n = 0;
          while ($urandom_range(99) < gap_pct) @(negedge axis_clk);
          ss_tvalid = 1'b1;
          ss_tdata  = in_q[k];
          ss_tlast  = (k == len - 1);
          while (!ss_tready && n < 400) begin
            @(negedge axis_clk);
            n++;
          end
          if (!ss_tready) begin
            check("input_accept_timeout", 32'd0, 32'd1);
            ss_tvalid = 1'b0;
            break;
          end
          @(negedge axis_clk);
          ss_tvalid = 1'b0;
          ss_tlast  = 1'b0;
        end
      end
      begin
        for (int k = 0; k < len; k++) begin
          logic        got = 1'b0;
          logic        held = 1'b0;
          logic [31:0] held_data = '0;
          int          n = 0;
          while (!got && n < 1000) begin
            sm_tready = ($urandom_range(99) >= stall_pct);
            if (sm_tvalid) begin
              if (held) check("data_stable_while_stalled", sm_tdata, held_data);
              if (sm_tready) begin
                if (exp_q.size() == 0) begin
                  check("unexpected_output", 32'd0, 32'd1);
                end else begin
                  check($sformatf("out[%0d]", k), sm_tdata, exp_q.pop_front());
                end
                check($sformatf("tlast[%0d]", k), {31'd0, sm_tlast}, {31'd0, (k == len - 1)});
                got = 1'b1;
              end else begin
                held      = 1'b1;
                held_data = sm_tdata;
              end
            end
            @(negedge axis_clk);
            n++;
          end
          sm_tready = 1'b0;
          if (!got) begin
            check("output_timeout", 32'd0, 32'd1);
            break;
          end
        end
      end
    join
  endtask

  task automatic run_vec(input int v);
    int len = int'(vecs[v].len);
    int d0;
    for (int i = 0; i < NTAP; i++) tap_mem[i] = vecs[v].taps[i];
    in_q.delete();
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      in_q.push_back(vecs[v].din[k]);
      exp_q.push_back(vecs[v].dout[k]);
    end
    d0 = done_cnt;
    start_run(len);
    run_stream(len, int'(vecs[v].gap_pct), int'(vecs[v].stall_pct));
    wait_idle();
    check($sformatf("vec%0d_done_pulses", v), done_cnt - d0, 32'd1);
    check($sformatf("vec%0d_queue_empty", v), exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] rtaps [NTAP];
    logic [31:0] hist [NTAP];
    logic [31:0] y;
    int d0, v0, r0, t0, n;

    // Vector table; every expected value is derived by hand.
    // 0: unit taps, ramp 1..5 -> running sums 1,3,6,10,15.
    // 1: taps i+1, impulse then zeros -> 1..11, 0, 0.
    // 2: unit taps, all ones -> 1..11, then 11 (history wraps the buffer).
    // 3: same as 2 again; a second run must start from zero history.
    for (int v = 0; v < 4; v++) vecs[v] = '0;
    vecs[0].len = 5;
    for (int i = 0; i < NTAP; i++) vecs[0].taps[i] = 1;
    for (int k = 0; k < 5; k++) vecs[0].din[k] = k + 1;
    vecs[0].dout[0] = 1;  vecs[0].dout[1] = 3;  vecs[0].dout[2] = 6;
    vecs[0].dout[3] = 10; vecs[0].dout[4] = 15;
    vecs[1].len = 13; vecs[1].stall_pct = 30;
    for (int i = 0; i < NTAP; i++) vecs[1].taps[i] = i + 1;
    vecs[1].din[0] = 1;
    for (int k = 0; k < 11; k++) vecs[1].dout[k] = k + 1;
    for (int v = 2; v < 4; v++) begin
      vecs[v].len = 20; vecs[v].gap_pct = 20; vecs[v].stall_pct = 20;
      for (int i = 0; i < NTAP; i++) vecs[v].taps[i] = 1;
      for (int k = 0; k < 20; k++) begin
        vecs[v].din[k]  = 1;
        vecs[v].dout[k] = (k < 11) ? k + 1 : 11;
      end
    end

    // Reset state.
    repeat (3) @(negedge axis_clk);
    check("rst_ap_idle",   {31'd0, ap_idle},   32'd1);
    check("rst_ap_done",   {31'd0, ap_done},   32'd0);
    check("rst_ss_tready", {31'd0, ss_tready}, 32'd0);
    check("rst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
    check("rst_sm_tlast",  {31'd0, sm_tlast},  32'd0);
    check("rst_sm_tdata",  sm_tdata,           32'd0);
    check("rst_enables",   {20'd0, tap_re, dat_re, dat_we}, 32'd0);
    check("rst_addrs",     {8'd0, dat_waddr, dat_raddr}, 32'd0);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Input-handshake-to-valid latency: the result is valid NTAP+2 cycles
    // after the handshake cycle, i.e. NTAP+1 clock edges after the
    // handshake edge.
    for (int i = 0; i < NTAP; i++) tap_mem[i] = 1;
    start_run(1);
    n = 0;
    while (!ss_tready && n < 100) begin @(negedge axis_clk); n++; end
    ss_tvalid = 1'b1; ss_tdata = 32'd5;
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    t0 = cyc; n = 0;
    while (!sm_tvalid && n < 100) begin @(negedge axis_clk); n++; end
    check("latency_edges", cyc - t0, NTAP + 1);
    check("latency_data",  sm_tdata, 32'd5);
    check("latency_tlast", {31'd0, sm_tlast}, 32'd1);
    sm_tready = 1'b1;
    @(negedge axis_clk);
    sm_tready = 1'b0;
    wait_idle();

    // Random signed samples and taps against a 32-bit wrapping model.
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < NTAP; i++) begin
      rtaps[i]   = $urandom;
      tap_mem[i] = rtaps[i];
      hist[i]    = '0;
    end
    for (int k = 0; k < 30; k++) begin
      for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = $urandom;
      y = '0;
      for (int i = 0; i < NTAP; i++) y = y + rtaps[i] * hist[i];
      in_q.push_back(hist[0]);
      exp_q.push_back(y);
    end
    d0 = done_cnt;
    start_run(30);
    run_stream(30, 30, 40);
    wait_idle();
    check("rand_done_pulses", done_cnt - d0, 32'd1);

    // ap_start pulsed during MAC, with a different length, must be ignored.
    for (int i = 0; i < NTAP; i++) tap_mem[i] = 1;
    in_q.delete(); exp_q.delete();
    in_q.push_back(7); in_q.push_back(8); in_q.push_back(9);
    exp_q.push_back(7); exp_q.push_back(15); exp_q.push_back(24);
    d0 = done_cnt; v0 = valid_cnt;
    start_run(3);
    fork
      run_stream(3, 0, 0);
      begin
        n = 0;
        while (!dat_re[0] && n < 200) begin @(negedge axis_clk); n++; end
        check("mac_seen", {31'd0, dat_re[0]}, 32'd1);
        data_length = 1;
        ap_start    = 1'b1;
        @(negedge axis_clk);
        ap_start = 1'b0;
      end
    join
    wait_idle();
    check("start_in_mac_done_pulses", done_cnt - d0, 32'd1);
    check("start_in_mac_queue_empty", exp_q.size(), 32'd0);

    // Zero-length run: CLEAR then DONE, with no stream activity.
    d0 = done_cnt; v0 = valid_cnt; r0 = tready_cnt;
    start_run(0);
    wait_idle();
    check("len0_done_pulses", done_cnt - d0,   32'd1);
    check("len0_no_tvalid",   valid_cnt - v0,  32'd0);
    check("len0_no_tready",   tready_cnt - r0, 32'd0);

    // Reset while a result is waiting in OUT.
    start_run(3);
    n = 0;
    while (!ss_tready && n < 100) begin @(negedge axis_clk); n++; end
    ss_tvalid = 1'b1; ss_tdata = 32'd4;
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    n = 0;
    while (!sm_tvalid && n < 100) begin @(negedge axis_clk); n++; end
    check("rst_mid_reached_out", {31'd0, sm_tvalid}, 32'd1);
    #2 axis_rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid",  {31'd0, sm_tvalid}, 32'd0);
    check("rst_mid_idle",    {31'd0, ap_idle},   32'd1);
    check("rst_mid_tready",  {31'd0, ss_tready}, 32'd0);
    @(negedge axis_clk);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
